// File: rtl/butterfly_pkg.sv
// Shared helpers for the butterfly fabric: stage count and
// the position arithmetic that wires the switch stages.
package butterfly_pkg;

  typedef logic [1:0] pair_t;

  function automatic int unsigned stages(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned partner(
    input int unsigned j,
    input int unsigned s,
    input int unsigned l
  );
    return j ^ (1 << (l - 1 - s));
  endfunction

  function automatic int unsigned route_bit(
    input int unsigned dst,
    input int unsigned s,
    input int unsigned l
  );
    return (dst >> (l - 1 - s)) & 1;
  endfunction

  // m-th pair of a stage: insert a 0 at bit b of m
  function automatic int unsigned low_pos(
    input int unsigned m,
    input int unsigned b
  );
    return ((m >> b) << (b + 1)) | (m & ((1 << b) - 1));
  endfunction

endpackage

// File: rtl/butterfly_switch.sv
// 2x2 registered switch: routes on one destination bit,
// round-robin arbitration per output register.
module butterfly_switch
  import butterfly_pkg::*;
#(
  parameter int DW      = 35,
  parameter int SEL_BIT = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up0_valid,
  output logic          up0_ready,
  input  logic [DW-1:0] up0_data,
  input  logic          up1_valid,
  output logic          up1_ready,
  input  logic [DW-1:0] up1_data,
  output logic          dn0_valid,
  input  logic          dn0_ready,
  output logic [DW-1:0] dn0_data,
  output logic          dn1_valid,
  input  logic          dn1_ready,
  output logic [DW-1:0] dn1_data
);

  pair_t           uv;
  pair_t           ur;
  pair_t           dr;
  pair_t           vq;
  pair_t           ptr;
  pair_t           load;
  pair_t           cont;
  logic [1:0][1:0] req;
  logic [1:0][1:0] gnt;
  logic [DW-1:0]   ud [2];
  logic [DW-1:0]   dq [2];

  assign uv    = {up1_valid, up0_valid};
  assign dr    = {dn1_ready, dn0_ready};
  assign ud[0] = up0_data;
  assign ud[1] = up1_data;

  assign up0_ready = ur[0];
  assign up1_ready = ur[1];
  assign dn0_valid = vq[0];
  assign dn1_valid = vq[1];
  assign dn0_data  = dq[0];
  assign dn1_data  = dq[1];

  // ptr set means input 1 is favoured on contention
  always_comb begin
    req  = '0;
    gnt  = '0;
    cont = '0;
    load = '0;
    ur   = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 2; i++) begin
        req[p][i] = uv[i] && (ud[i][SEL_BIT] == p[0]);
      end
      cont[p]   = &req[p];
      gnt[p][0] = req[p][0] && (!req[p][1] || !ptr[p]);
      gnt[p][1] = req[p][1] && (!req[p][0] || ptr[p]);
      load[p]   = !vq[p] || dr[p];
      ur        = ur | (gnt[p] & {2{load[p]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq    <= '0;
      ptr   <= '0;
      dq[0] <= '0;
      dq[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (load[p]) begin
          vq[p] <= |gnt[p];
          unique case (1'b1)
            gnt[p][0]: dq[p] <= ud[0];
            gnt[p][1]: dq[p] <= ud[1];
            default: ;
          endcase
          if (cont[p]) ptr[p] <= !ptr[p];
        end
      end
    end
  end

endmodule

// File: rtl/butterfly.sv
// N-port butterfly fabric: log2(N) stages of registered 2x2
// switches, destination index carried in the word's top bits.
module butterfly
  import butterfly_pkg::*;
#(
  parameter int DW = 35,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid [N-1:0],
  output logic          i_ready [N-1:0],
  input  logic [DW-1:0] i_data  [N-1:0],
  output logic          o_valid [N-1:0],
  input  logic          o_ready [N-1:0],
  output logic [DW-1:0] o_data  [N-1:0]
);

  localparam int L = stages(N);

  for (genvar s = 0; s < L; s++) begin : stg
    logic          uv [N-1:0];
    logic          ur [N-1:0];
    logic [DW-1:0] ud [N-1:0];
    logic          v  [N-1:0];
    logic          r  [N-1:0];
    logic [DW-1:0] d  [N-1:0];

    for (genvar k = 0; k < N; k++) begin : port
      if (s == 0) begin : head
        assign uv[k]      = i_valid[k];
        assign ud[k]      = i_data[k];
        assign i_ready[k] = ur[k] & rst_n;
      end else begin : link
        assign uv[k] = stg[s-1].v[k];
        assign ud[k] = stg[s-1].d[k];
      end
      if (s == L - 1) begin : tail
        assign r[k]       = o_ready[k];
        assign o_valid[k] = v[k];
        assign o_data[k]  = d[k];
      end else begin : fwd
        assign r[k] = stg[s+1].ur[k];
      end
    end

    // stage s routes on destination bit L-1-s, i.e. word bit DW-1-s
    for (genvar m = 0; m < N / 2; m++) begin : sw
      localparam int A = int'(low_pos(m, L - 1 - s));
      localparam int B = int'(partner(A, s, L));

      butterfly_switch #(
        .DW      (DW),
        .SEL_BIT (DW - 1 - s)
      ) u_switch (
        .clk       (clk),
        .rst_n     (rst_n),
        .up0_valid (uv[A]),
        .up0_ready (ur[A]),
        .up0_data  (ud[A]),
        .up1_valid (uv[B]),
        .up1_ready (ur[B]),
        .up1_data  (ud[B]),
        .dn0_valid (v[A]),
        .dn0_ready (r[A]),
        .dn0_data  (d[A]),
        .dn1_valid (v[B]),
        .dn1_ready (r[B]),
        .dn1_data  (d[B])
      );
    end
  end

endmodule

// File: tb/tb_butterfly.sv
// Self-checking bench for butterfly: directed sequence plus a
// per-(source,destination) FIFO scoreboard with latency tracking.
module tb_butterfly;

  localparam int N  = 8;
  localparam int DW = 35;
  localparam int L  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_valid [N-1:0];
  logic          i_ready [N-1:0];
  logic [DW-1:0] i_data  [N-1:0];
  logic          o_valid [N-1:0];
  logic          o_ready [N-1:0];
  logic [DW-1:0] o_data  [N-1:0];

  butterfly #(.DW(DW), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] w;
    int            e;
  } ent_t;

  ent_t sbq [N*N][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rcv    = 0;
  bit   lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pk(input logic a [N-1:0]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] data_or(input logic [DW-1:0] a [N-1:0]);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = r | a[i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // reference: every word is owned by the FIFO of its (src,dst) pair
  always @(negedge clk) begin : monitor
    ent_t en;
    int   idx;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (i_valid[k] && i_ready[k]) begin
          en.w = i_data[k];
          en.e = cyc + 1;
          sbq[k * N + int'(i_data[k][DW-1 -: L])].push_back(en);
        end
      end
      for (int p = 0; p < N; p++) begin
        if (o_valid[p] && o_ready[p]) begin
          idx = int'(o_data[p][2:0]) * N + p;
          chk($sformatf("expected_word_p%0d", p),
              64'(sbq[idx].size() != 0), 64'd1);
          if (sbq[idx].size() != 0) begin
            en = sbq[idx].pop_front();
            chk($sformatf("data_p%0d", p), 64'(o_data[p]), 64'(en.w));
            if (lat_chk)
              chk($sformatf("latency_p%0d", p), 64'(cyc), 64'(en.e + 2));
            rcv++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic send1(input int s, input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    i_valid[s] = 1'b1;
    i_data[s]  = w;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = i_ready[s];
      @(posedge clk);
      #1;
    end
    i_valid[s] = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic contend(input int first, input int second, input string tag);
    logic [DW-1:0] wf;
    logic [DW-1:0] ws;
    wf = {3'd2, 32'(first)};
    ws = {3'd2, 32'(second)};
    i_valid[first]  = 1'b1;
    i_data[first]   = wf;
    i_valid[second] = 1'b1;
    i_data[second]  = ws;
    @(negedge clk);
    chk({tag, "_win_rdy"}, 64'(i_ready[first]), 64'd1);
    chk({tag, "_lose_rdy"}, 64'(i_ready[second]), 64'd0);
    @(posedge clk);
    #1;
    i_valid[first] = 1'b0;
    @(negedge clk);
    chk({tag, "_retry_rdy"}, 64'(i_ready[second]), 64'd1);
    @(posedge clk);
    #1;
    i_valid[second] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_out1_valid"}, 64'(o_valid[2]), 64'd1);
    chk({tag, "_out1_data"}, 64'(o_data[2]), 64'(wf));
    @(negedge clk);
    chk({tag, "_out2_valid"}, 64'(o_valid[2]), 64'd1);
    chk({tag, "_out2_data"}, 64'(o_data[2]), 64'(ws));
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [DW-1:0] cur;
    logic [DW-1:0] w0;
    int            seq;
    int            rcv0;
    int            total;
    bit            got;
    bit            seen;

    for (int k = 0; k < N; k++) begin
      i_valid[k] = 1'b0;
      i_data[k]  = '0;
      o_ready[k] = 1'b1;
    end

    #1 rst_n = 1'b0;
    #2;
    chk("reset_o_valid", 64'(pk(o_valid)), 64'd0);
    chk("reset_o_data", 64'(data_or(o_data)), 64'd0);
    chk("reset_i_ready", 64'(pk(i_ready)), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    contend(0, 4, "cont_a");
    contend(4, 0, "cont_b");
    repeat (3) @(posedge clk);
    #1;

    lat_chk = 1'b1;
    rcv0 = rcv;
    for (int s = 0; s < N; s++)
      for (int d = 0; d < N; d++)
        send1(s, {3'(d), 32'(s)});
    repeat (5) @(posedge clk);
    #1;
    chk("a2a_received", 64'(rcv - rcv0), 64'd64);

    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < N; k++) begin
        i_valid[k] = 1'b1;
        i_data[k]  = {3'(k), c[28:0], 3'(k)};
      end
      @(negedge clk);
      chk("perm_i_ready", 64'(pk(i_ready)), 64'hff);
      if (c >= 3) chk("perm_o_valid", 64'(pk(o_valid)), 64'hff);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < N; k++) i_valid[k] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    lat_chk = 1'b0;

    seq = 0;
    cur = {3'd5, 29'($urandom), 3'd1};
    w0  = cur;
    o_ready[5] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i_valid[1] = 1'b1;
      i_data[1]  = cur;
      @(negedge clk);
      got = i_ready[1];
      if (o_valid[5]) chk("bp_stable", 64'(o_data[5]), 64'(w0));
      @(posedge clk);
      #1;
      if (got) begin
        seq++;
        cur = {3'd5, 29'($urandom), 3'd1};
      end
    end
    @(negedge clk);
    chk("bp_i_ready_low", 64'(i_ready[1]), 64'd0);
    chk("bp_accepted", 64'(seq), 64'd3);
    chk("bp_o_valid", 64'(o_valid[5]), 64'd1);
    chk("bp_o_data", 64'(o_data[5]), 64'(w0));
    @(posedge clk);
    #1;
    o_ready[5] = 1'b1;
    for (int c = 0; c < 30 && seq < 6; c++) begin
      i_data[1] = cur;
      @(negedge clk);
      got = i_ready[1];
      @(posedge clk);
      #1;
      if (got) begin
        seq++;
        cur = {3'd5, 29'($urandom), 3'd1};
      end
    end
    i_valid[1] = 1'b0;
    chk("bp_total_sent", 64'(seq), 64'd6);
    repeat (8) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sbq[1 * N + 5].size()), 64'd0);

    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) begin
        i_valid[k] = 1'b1;
        i_data[k]  = {3'($urandom), 29'($urandom), 3'(k)};
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", 64'(pk(o_valid)), 64'd0);
    chk("midrst_o_data", 64'(data_or(o_data)), 64'd0);
    chk("midrst_i_ready", 64'(pk(i_ready)), 64'd0);
    for (int k = 0; k < N; k++) i_valid[k] = 1'b0;
    for (int i = 0; i < N * N; i++) sbq[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur = {3'd6, 29'($urandom), 3'd3};
    send1(3, cur);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (o_valid[6]) begin
        seen = 1'b1;
        chk("post_rst_data", 64'(o_data[6]), 64'(cur));
      end
    end
    chk("post_rst_seen", 64'(seen), 64'd1);
    repeat (4) @(posedge clk);
    #1;

    total = 0;
    for (int i = 0; i < N * N; i++) total += sbq[i].size();
    chk("all_delivered", 64'(total), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
